// File: rtl/cordic_angnorm_rom_arbiter_pkg.sv
// rtl/cordic_angnorm_rom_arbiter_pkg.sv - shared widths, requester ids and in-flight tag type
package cordic_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 4;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } inflight_t;

endpackage

// File: rtl/cordic_angnorm_rom_arbiter_if.sv
// rtl/cordic_angnorm_rom_arbiter_if.sv - request, response and ROM signals of the normalize-ROM arbiter
interface cordic_angnorm_rom_arbiter_if
  import cordic_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              iReq0_valid;
  logic              iReq1_valid;
  logic [ADDR_W-1:0] iReq0_addr;
  logic [ADDR_W-1:0] iReq1_addr;
  logic              oReq0_ready;
  logic              oReq1_ready;
  logic              oResp0_valid;
  logic              oResp1_valid;
  logic [DATA_W-1:0] oResp0_data;
  logic [DATA_W-1:0] oResp1_data;
  logic              iResp0_ready;
  logic              iResp1_ready;
  logic [ADDR_W-1:0] oRom_addr;
  logic              oRom_addr_valid;
  logic [DATA_W-1:0] iRom_data;

  modport slave (
    input  iReq0_valid, iReq1_valid, iReq0_addr, iReq1_addr,
    output oReq0_ready, oReq1_ready,
    output oResp0_valid, oResp1_valid, oResp0_data, oResp1_data,
    input  iResp0_ready, iResp1_ready,
    output oRom_addr, oRom_addr_valid,
    input  iRom_data
  );

  modport master (
    output iReq0_valid, iReq1_valid, iReq0_addr, iReq1_addr,
    input  oReq0_ready, oReq1_ready,
    input  oResp0_valid, oResp1_valid, oResp0_data, oResp1_data,
    output iResp0_ready, iResp1_ready,
    input  oRom_addr, oRom_addr_valid,
    output iRom_data
  );

endinterface

// File: rtl/cordic_resp_slot.sv
// rtl/cordic_resp_slot.sv - one-entry response holding register; a load wins over a same-cycle drain
module cordic_resp_slot
  import cordic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cordic_angnorm_rom_arbiter.sv
// rtl/cordic_angnorm_rom_arbiter.sv - two-requester arbiter for the external normalize ROM; CORDIC_ANGNORM_ROUND_ROBIN_EN selects round-robin over fixed priority
module cordic_angnorm_rom_arbiter
  import cordic_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                         iClk,
  input  logic                         iRst,
  cordic_angnorm_rom_arbiter_if.slave  bus
);

  inflight_t         r_tag;
  logic [ADDR_W-1:0] r_rom_addr;

  logic w_elig0;
  logic w_elig1;
  logic w_cand0;
  logic w_cand1;
  logic w_pick1;
  logic w_grant0;
  logic w_grant1;
  logic w_load0;
  logic w_load1;

`ifdef CORDIC_ANGNORM_ROUND_ROBIN_EN
  logic r_last;
`endif

  // A requester is blocked while its own lookup is in flight or its slot cannot take a result.
  always_comb begin
    w_elig0 = !iRst && !(r_tag.valid && r_tag.id == REQ_ID_0)
              && (!bus.oResp0_valid || bus.iResp0_ready);
    w_elig1 = !iRst && !(r_tag.valid && r_tag.id == REQ_ID_1)
              && (!bus.oResp1_valid || bus.iResp1_ready);
    w_cand0 = w_elig0 && bus.iReq0_valid;
    w_cand1 = w_elig1 && bus.iReq1_valid;
`ifdef CORDIC_ANGNORM_ROUND_ROBIN_EN
    w_pick1 = (r_last == REQ_ID_0);
`else
    w_pick1 = 1'b0;
`endif
    w_grant1 = w_cand1 && (!w_cand0 || w_pick1);
    w_grant0 = w_cand0 && !w_grant1;
  end

  assign bus.oReq0_ready     = w_grant0;
  assign bus.oReq1_ready     = w_grant1;
  assign bus.oRom_addr_valid = w_grant0 || w_grant1;
  assign bus.oRom_addr       = w_grant1 ? bus.iReq1_addr :
                               w_grant0 ? bus.iReq0_addr : r_rom_addr;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_tag      <= '0;
      r_rom_addr <= '0;
    end else begin
      r_tag.valid <= w_grant0 || w_grant1;
      if (w_grant0 || w_grant1) begin
        r_tag.id   <= w_grant1 ? REQ_ID_1 : REQ_ID_0;
        r_rom_addr <= bus.oRom_addr;
      end
    end
  end

`ifdef CORDIC_ANGNORM_ROUND_ROBIN_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_last <= REQ_ID_1;
    end else if (w_grant0 || w_grant1) begin
      r_last <= w_grant1 ? REQ_ID_1 : REQ_ID_0;
    end
  end
`endif

  // The ROM output registered one cycle after issue belongs to the tagged requester.
  assign w_load0 = r_tag.valid && (r_tag.id == REQ_ID_0);
  assign w_load1 = r_tag.valid && (r_tag.id == REQ_ID_1);

  cordic_resp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .i_clk       (iClk),
    .i_rst       (iRst),
    .i_load      (w_load0),
    .i_load_data (bus.iRom_data),
    .i_ready     (bus.iResp0_ready),
    .o_valid     (bus.oResp0_valid),
    .o_data      (bus.oResp0_data)
  );

  cordic_resp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .i_clk       (iClk),
    .i_rst       (iRst),
    .i_load      (w_load1),
    .i_load_data (bus.iRom_data),
    .i_ready     (bus.iResp1_ready),
    .o_valid     (bus.oResp1_valid),
    .o_data      (bus.oResp1_data)
  );

endmodule

// File: doc/cordic_angnorm_rom_arbiter.md
CORDIC_ANGNORM_ROM_ARBITER -- requirements
Module: cordic_angnorm_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 4, ROM sign-nibble width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port iClk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have ports iReq0_valid / iReq1_valid, input, 1 bit each: lookup request.
REQ-007 SHALL have ports iReq0_addr / iReq1_addr, input, ADDR_W each: normalize-ROM address.
REQ-008 SHALL have ports oReq0_ready / oReq1_ready, output, 1 bit each: grant; a request transfers when valid&ready.
REQ-009 SHALL have ports oResp0_valid / oResp1_valid, output, 1 bit each: response held.
REQ-010 SHALL have ports oResp0_data / oResp1_data, output, DATA_W each: sine/cos sign nibble.
REQ-011 SHALL have ports iResp0_ready / iResp1_ready, input, 1 bit each: consumer accepts response.
REQ-012 SHALL have port oRom_addr, output, ADDR_W: address to the angle-normalize ROM.
REQ-013 SHALL have port oRom_addr_valid, output, 1 bit: ROM read issued this cycle.
REQ-014 SHALL have port iRom_data, input, DATA_W: ROM registered output, valid one cycle after issue.

Function
REQ-015 SHALL grant at most one requester per cycle; oReq0_ready and oReq1_ready never both high.
REQ-016 SHALL treat requester n as eligible iff no lookup for n is in flight, and resp slot n is empty or drains this cycle (oRespn_valid & iRespn_ready).
REQ-017 SHALL assert oReqn_ready only when n is eligible and selected; ready is independent of iReqn_valid only through eligibility and selection.
REQ-018 SHALL, in grant cycle T, drive oRom_addr = granted address and oRom_addr_valid = 1 combinationally; otherwise oRom_addr_valid = 0 and oRom_addr holds its last value.
REQ-019 SHALL register an in-flight tag (valid + requester id) at end of T; at end of T+1 load iRom_data into slot n, so oRespn_valid rises in cycle T+2 (latency 2).
REQ-020 SHALL hold oRespn_valid and oRespn_data stable until oRespn_valid & iRespn_ready; no response is ever dropped or overwritten.
REQ-021 SHALL, on simultaneous drain and load of slot n in the same cycle, leave slot n valid with the new data.
REQ-022 SHALL sustain one grant per cycle when both requesters alternate with ready consumers; a single requester is limited to one grant per 2 cycles.
REQ-023 SHALL, when both are eligible and valid, select per REQ-029/REQ-030; when only one is eligible and valid, select it.

Reset
REQ-024 SHALL, while iRst=1 at a rising edge, clear in-flight tag, both slots (oRespn_valid=0, oRespn_data=0), oRom_addr=0 and the priority pointer (last-granted = 1).
REQ-025 SHALL hold oReq0_ready=oReq1_ready=0 and oRom_addr_valid=0 during any cycle where iRst=1.
REQ-026 SHALL discard any lookup in flight at reset mid-operation; no response appears after reset release for it.

Configuration
REQ-027 SHALL support macro CORDIC_ANGNORM_ROUND_ROBIN_EN selecting the arbitration policy.
REQ-028 SHALL keep all other behaviour identical regardless of the macro.
REQ-029 SHALL, with the macro defined, grant the requester not granted last when both contend; the pointer updates on every grant.
REQ-030 SHALL, without the macro, always grant requester 0 on contention; the pointer is not implemented.

Structure
REQ-031 SHALL place ADDR_W/DATA_W defaults and requester-id constants (REQ_ID_0, REQ_ID_1) in shared package cordic_pkg.
REQ-032 SHALL implement each response slot as sub-module cordic_resp_slot, instantiated twice; arbitration stays in the top.
REQ-033 SHALL NOT contain the ROM; it connects to the existing normalize ROM externally.

Verification
REQ-034 SHALL cover single request: req0 addr=5 at T, ROM model returns 4'b1010 -> oResp0_valid=1, data=1010 at T+2.
REQ-035 SHALL cover contention with macro: both valid continuously from reset, consumers ready -> grants 0,1,0,1; ROM addr follows the requests.
REQ-036 SHALL cover contention without macro: both valid, consumers ready -> requester 0 granted at T and T+2; requester 1 granted only at T+1, T+3.
REQ-037 SHALL cover backpressure: iResp0_ready=0 for 5 cycles with req0 valid -> exactly one grant to 0, slot data stable, next grant in the cycle ready rises.
REQ-038 SHALL cover reset mid-flight: iRst=1 in cycle T+1 after grant at T -> no oResp0_valid after release, outputs zero.
REQ-039 SHALL cover drain+load: slot 1 valid, iResp1_ready=1 in the cycle new data loads -> oResp1_valid stays 1 with new nibble.
